// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared funct3 codes, FSM state encoding and the access
//               legality check for the handshaked data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

   // RV32 load/store funct3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // True when funct3 is legal for the direction and the address is
   // naturally aligned for the access size.
   function automatic logic access_ok(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
      logic ok;
      case (funct3)
         F3_B:         ok = 1'b1;
         F3_H:         ok = ~addr_lo[0];
         F3_W:         ok = (addr_lo == 2'b00);
         F3_BU:        ok = ~we;
         F3_HU:        ok = ~we & ~addr_lo[0];
         default:      ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_fmt
// Description : Combinational byte-lane steering. Produces store byte
//               enables with lane-replicated write data, and the sign- or
//               zero-extended load result from a read word.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_fmt
   import data_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_merged,
   output logic [31:0] load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Store side: replicate the low bytes into every lane and enable only
   // the lanes the access touches.
   always_comb begin
      byte_en      = 4'b0000;
      wdata_merged = wdata;
      case (funct3)
         F3_B: begin
            wdata_merged = {4{wdata[7:0]}};
            byte_en      = 4'b0001 << addr_lo;
         end
         F3_H: begin
            wdata_merged = {2{wdata[15:0]}};
            byte_en      = addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         F3_W: begin
            wdata_merged = wdata;
            byte_en      = 4'b1111;
         end
         default: begin
            wdata_merged = wdata;
            byte_en      = 4'b0000;
         end
      endcase
   end

   // Load side: pick the addressed lane and extend it to a full word.
   always_comb begin
      w_byte    = 8'h00;
      w_half    = addr_lo[1] ? rword[31:16] : rword[15:0];
      load_data = 32'h0000_0000;
      case (addr_lo)
         2'd0:    w_byte = rword[7:0];
         2'd1:    w_byte = rword[15:8];
         2'd2:    w_byte = rword[23:16];
         default: w_byte = rword[31:24];
      endcase
      case (funct3)
         F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
         F3_H:    load_data = {{16{w_half[15]}}, w_half};
         F3_W:    load_data = rword;
         F3_BU:   load_data = {24'h000000, w_byte};
         F3_HU:   load_data = {16'h0000, w_half};
         default: load_data = 32'h0000_0000;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_hs
// Description : Valid/ready data memory with RV32 sub-word loads/stores,
//               programmable wait states, registered read data and
//               misalignment / illegal-funct3 error reporting.
//               MEM_DEPTH must be a power of two (>= 4); DATA_WIDTH is 32.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_hs
   import data_mem_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int         c_idx_w   = $clog2(MEM_DEPTH);
   localparam logic [3:0] c_ws_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    we_q, we_d;
   logic [2:0]              f3_q, f3_d;
   logic [c_idx_w+1:0]      addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;

   logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

   logic                    w_acc_we;
   logic [2:0]              w_acc_f3;
   logic [c_idx_w+1:0]      w_acc_addr;
   logic [DATA_WIDTH-1:0]   w_acc_wdata;
   logic [c_idx_w-1:0]      w_idx;
   logic [DATA_WIDTH-1:0]   w_rword;
   logic                    w_ok;
   logic [3:0]              w_be;
   logic [DATA_WIDTH-1:0]   w_wmerged;
   logic [DATA_WIDTH-1:0]   w_ldata;
   logic                    w_enter_resp;
   logic                    w_commit;

   // With zero wait states the access happens on the acceptance edge, so the
   // live request is used in IDLE; afterwards the latched copy is used.
   assign w_acc_we    = (state_q == IDLE) ? req_we             : we_q;
   assign w_acc_f3    = (state_q == IDLE) ? req_funct3         : f3_q;
   assign w_acc_addr  = (state_q == IDLE) ? req_addr[c_idx_w+1:0] : addr_q;
   assign w_acc_wdata = (state_q == IDLE) ? req_wdata          : wdata_q;

   assign w_idx    = w_acc_addr[c_idx_w+1:2];
   assign w_rword  = mem_q[w_idx];
   assign w_ok     = access_ok(w_acc_we, w_acc_f3, w_acc_addr[1:0]);
   assign w_commit = w_enter_resp & w_acc_we & w_ok;

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   // Address bits above the word index are deliberately ignored (wrap).
   generate
      if (ADDR_WIDTH > c_idx_w + 2) begin : g_addr_upper
         logic unused_addr_hi;
         assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:c_idx_w+2];
      end
   endgenerate

   mem_lane_fmt u_lane_fmt (
      .funct3       (w_acc_f3),
      .addr_lo      (w_acc_addr[1:0]),
      .wdata        (w_acc_wdata),
      .rword        (w_rword),
      .byte_en      (w_be),
      .wdata_merged (w_wmerged),
      .load_data    (w_ldata)
   );

   // Next-state logic: accept, count wait states, perform the access on RESP
   // entry and hold the response until it is taken.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      f3_d         = f3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      w_enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr[c_idx_w+1:0];
               wdata_d = req_wdata;
               if (WAIT_STATES == 0) begin
                  state_d      = RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = c_ws_load;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d      = RESP;
               w_enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (w_enter_resp) begin
         err_d   = ~w_ok;
         rdata_d = (w_ok && !w_acc_we) ? w_ldata : '0;
      end
   end

   // Control and response registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage array: byte-lane write on the committing edge, never reset.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               mem_q[w_idx][8*i +: 8] <= w_wmerged[8*i +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_hs
// Description : Directed self-checking bench for data_mem_hs. Three
//               instances: WAIT_STATES = 0, 3 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_hs;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [2:0]  v_req_valid = 3'b000;
   logic [2:0]  v_rsp_ready = 3'b000;

   logic        rr0, rr1, rr2, rv0, rv1, rv2, re0, re1, re2;
   logic [31:0] rd0, rd1, rd2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_hs #(.WAIT_STATES(0)) u_dut0 (
      .clk(clk), .reset(reset), .req_valid(v_req_valid[0]), .req_ready(rr0),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv0), .rsp_ready(v_rsp_ready[0]), .rsp_rdata(rd0), .rsp_err(re0));

   data_mem_hs #(.WAIT_STATES(3)) u_dut1 (
      .clk(clk), .reset(reset), .req_valid(v_req_valid[1]), .req_ready(rr1),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv1), .rsp_ready(v_rsp_ready[1]), .rsp_rdata(rd1), .rsp_err(re1));

   data_mem_hs #(.WAIT_STATES(2)) u_dut2 (
      .clk(clk), .reset(reset), .req_valid(v_req_valid[2]), .req_ready(rr2),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv2), .rsp_ready(v_rsp_ready[2]), .rsp_rdata(rd2), .rsp_err(re2));

   function automatic logic g_ready(input int i);
      return (i == 0) ? rr0 : (i == 1) ? rr1 : rr2;
   endfunction
   function automatic logic g_valid(input int i);
      return (i == 0) ? rv0 : (i == 1) ? rv1 : rv2;
   endfunction
   function automatic logic g_err(input int i);
      return (i == 0) ? re0 : (i == 1) ? re1 : re2;
   endfunction
   function automatic logic [31:0] g_rdata(input int i);
      return (i == 0) ? rd0 : (i == 1) ? rd1 : rd2;
   endfunction

   // One request/response exchange on instance i. lat counts clock edges from
   // the acceptance edge (inclusive) until rsp_valid is seen. hs_ok is cleared
   // if req_ready misbehaves or the response is unstable while held.
   task automatic txn(input int i, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                      output logic [31:0] rdata, output logic err, output int lat,
                      output logic hs_ok);
      hs_ok = 1'b1;
      @(negedge clk);
      if (!g_ready(i)) hs_ok = 1'b0;
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      v_req_valid[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v_req_valid[i] = 1'b0;
      req_we = ~we; req_funct3 = 3'b111; req_addr = ~addr; req_wdata = ~wdata;
      lat = 1;
      while (!g_valid(i) && lat < 64) begin
         if (g_ready(i)) hs_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (!g_valid(i)) begin
         checks++; errors++;
         $display("FAIL timeout inst=%0d: rsp_valid never rose (got 0, need 1)", i);
      end
      rdata = g_rdata(i);
      err   = g_err(i);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (!g_valid(i) || g_ready(i) || g_rdata(i) !== rdata || g_err(i) !== err)
            hs_ok = 1'b0;
      end
      v_rsp_ready[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v_rsp_ready[i] = 1'b0;
      if (g_valid(i) || !g_ready(i)) hs_ok = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (g_ready(i) !== 1'b1) begin errors++; $display("FAIL reset_ready inst=%0d got %b need 1", i, g_ready(i)); end
         checks++;
         if (g_valid(i) !== 1'b0) begin errors++; $display("FAIL reset_valid inst=%0d got %b need 0", i, g_valid(i)); end
         checks++;
         if (g_rdata(i) !== 32'h0) begin errors++; $display("FAIL reset_rdata inst=%0d got %h need 0", i, g_rdata(i)); end
         checks++;
         if (g_err(i) !== 1'b0) begin errors++; $display("FAIL reset_err inst=%0d got %b need 0", i, g_err(i)); end
      end
   endtask

   task automatic test_word();
      logic [31:0] rd; logic er; int lat; logic ok;
      txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, ok);
      checks++;
      if (lat != 1 || er !== 1'b0 || rd !== 32'h0 || ok !== 1'b1) begin
         errors++; $display("FAIL sw_word lat=%0d err=%b rdata=%h hs=%b need lat=1 err=0 rdata=0 hs=1", lat, er, rd, ok);
      end
      txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
         errors++; $display("FAIL lw_word got %h err=%b need deadbeef err=0", rd, er);
      end
      checks++;
      if (lat != 1 || ok !== 1'b1) begin
         errors++; $display("FAIL lw_latency got lat=%0d hs=%b need lat=1 hs=1", lat, ok);
      end
   endtask

   task automatic test_subword();
      logic [31:0] rd; logic er; int lat; logic ok;
      txn(0, 1'b1, 3'b010, 32'h20, 32'h0, 0, rd, er, lat, ok);
      txn(0, 1'b1, 3'b000, 32'h21, 32'hFFFFFF80, 0, rd, er, lat, ok);
      checks++;
      if (er !== 1'b0) begin errors++; $display("FAIL sb_err got %b need 0", er); end
      txn(0, 1'b0, 3'b000, 32'h21, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got %h need ffffff80", rd); end
      txn(0, 1'b0, 3'b100, 32'h21, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu got %h need 00000080", rd); end
      txn(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'h00008000) begin errors++; $display("FAIL lw_after_sb got %h need 00008000", rd); end
      txn(0, 1'b1, 3'b001, 32'h22, 32'hABCD1234, 0, rd, er, lat, ok);
      txn(0, 1'b0, 3'b101, 32'h22, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'h00001234) begin errors++; $display("FAIL lhu got %h need 00001234", rd); end
      txn(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'h12348000) begin errors++; $display("FAIL lw_after_sh got %h need 12348000", rd); end
      txn(0, 1'b0, 3'b001, 32'h20, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'hFFFF8000) begin errors++; $display("FAIL lh_neg got %h need ffff8000", rd); end
      txn(0, 1'b0, 3'b001, 32'h22, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'h00001234) begin errors++; $display("FAIL lh_pos got %h need 00001234", rd); end
      txn(0, 1'b0, 3'b000, 32'h23, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'h00000012) begin errors++; $display("FAIL lb_lane3 got %h need 00000012", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat; logic ok;
      txn(0, 1'b1, 3'b010, 32'h14, 32'hCAFEF00D, 0, rd, er, lat, ok);
      txn(0, 1'b0, 3'b010, 32'h13, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misaligned err=%b rdata=%h need err=1 rdata=0", er, rd); end
      txn(0, 1'b1, 3'b001, 32'h15, 32'h00005555, 0, rd, er, lat, ok);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sh_misaligned err=%b rdata=%h need err=1 rdata=0", er, rd); end
      txn(0, 1'b1, 3'b011, 32'h14, 32'h11223344, 0, rd, er, lat, ok);
      checks++;
      if (er !== 1'b1) begin errors++; $display("FAIL st_f3_011 err=%b need 1", er); end
      txn(0, 1'b1, 3'b100, 32'h14, 32'h000000EE, 0, rd, er, lat, ok);
      checks++;
      if (er !== 1'b1) begin errors++; $display("FAIL st_f3_100 err=%b need 1", er); end
      txn(0, 1'b0, 3'b011, 32'h14, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ld_f3_011 err=%b rdata=%h need err=1 rdata=0", er, rd); end
      txn(0, 1'b0, 3'b010, 32'h14, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL mem_unchanged err=%b got %h need err=0 cafef00d", er, rd); end
   endtask

   task automatic test_wrap();
      logic [31:0] rd; logic er; int lat; logic ok;
      txn(0, 1'b1, 3'b010, 32'h400, 32'hA5A5A5A5, 0, rd, er, lat, ok);
      txn(0, 1'b0, 3'b010, 32'h000, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_lw0 got %h need a5a5a5a5", rd); end
      txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_other got %h need deadbeef", rd); end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic er; int lat; logic ok;
      txn(1, 1'b1, 3'b010, 32'h30, 32'h13579BDF, 0, rd, er, lat, ok);
      checks++;
      if (lat != 4 || ok !== 1'b1) begin errors++; $display("FAIL ws3_store lat=%0d hs=%b need lat=4 hs=1", lat, ok); end
      txn(1, 1'b0, 3'b010, 32'h30, 32'h0, 5, rd, er, lat, ok);
      checks++;
      if (lat != 4) begin errors++; $display("FAIL ws3_latency got %0d need 4", lat); end
      checks++;
      if (rd !== 32'h13579BDF || er !== 1'b0) begin errors++; $display("FAIL ws3_rdata got %h err=%b need 13579bdf err=0", rd, er); end
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL ws3_hold_stable got %b need 1", ok); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat; logic ok;
      txn(2, 1'b1, 3'b010, 32'h8, 32'h22222222, 0, rd, er, lat, ok);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL ws2_latency got %0d need 3", lat); end
      txn(2, 1'b0, 3'b010, 32'h8, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'h22222222) begin errors++; $display("FAIL ws2_preload got %h need 22222222", rd); end
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h11111111;
      v_req_valid[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v_req_valid[2] = 1'b0;
      checks++;
      if (rr2 !== 1'b0 || rv2 !== 1'b0) begin errors++; $display("FAIL wait_state ready=%b valid=%b need 0 0", rr2, rv2); end
      reset = 1'b1;
      #2;
      checks++;
      if (rr2 !== 1'b1 || rv2 !== 1'b0 || rd2 !== 32'h0 || re2 !== 1'b0) begin
         errors++; $display("FAIL mid_reset ready=%b valid=%b rdata=%h err=%b need 1 0 0 0", rr2, rv2, rd2, re2);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      txn(2, 1'b0, 3'b010, 32'h8, 32'h0, 0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'h22222222 || er !== 1'b0) begin errors++; $display("FAIL store_cancelled got %h err=%b need 22222222 err=0", rd, er); end
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b0;
      test_word();
      test_subword();
      test_errors();
      test_wrap();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
